// File: rtl/pcap_replay_scheduler.sv
// rtl/pcap_replay_scheduler.sv - replays stored packets from memory for a set number of passes
// Zero-latency stream pass-through gated by a RUN/REWIND/DRAIN control FSM.
module pcap_replay_scheduler #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_CNT_WIDTH          = 32
) (
  input  logic                               axi_aclk,
  input  logic                               axi_aresetn,
  input  logic                               sw_rst,
  input  logic                               replay_start,
  input  logic                               replay_stop,
  input  logic [C_CNT_WIDTH-1:0]             replay_iter,
  input  logic [C_CNT_WIDTH-1:0]             replay_pkt_cnt,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic [C_M_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic                               s_axis_tvalid,
  input  logic                               s_axis_tlast,
  output logic                               s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tlast,
  input  logic                               m_axis_tready,
  output logic                               mem_rd_en,
  output logic                               mem_rewind,
  output logic                               replay_busy,
  output logic [C_CNT_WIDTH-1:0]             iter_done_cnt,
  output logic [C_CNT_WIDTH-1:0]             pkt_sent_cnt
);

  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, REWIND, DRAIN} state_t;

  state_t                 state;
  logic                   in_pkt;
  logic [C_CNT_WIDTH-1:0] iter_lat;
  logic [C_CNT_WIDTH-1:0] pkt_lat;
  logic [C_CNT_WIDTH-1:0] pass_cnt;
  logic                   pass_en;
  logic                   beat;
  logic                   pass_end;
  logic                   last_pass;

  assign pass_en = (state == RUN) || (state == DRAIN);

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tstrb  = s_axis_tstrb;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = pass_en & s_axis_tvalid;
  assign s_axis_tready = pass_en & m_axis_tready;

  assign beat      = m_axis_tvalid & m_axis_tready;
  assign pass_end  = beat & s_axis_tlast & (pass_cnt == pkt_lat - CNT_ONE);
  assign last_pass = (iter_lat != '0) && (iter_done_cnt + CNT_ONE == iter_lat);

  assign mem_rd_en   = pass_en;
  assign mem_rewind  = (state == REWIND);
  assign replay_busy = (state != IDLE);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state         <= IDLE;
      in_pkt        <= 1'b0;
      iter_lat      <= '0;
      pkt_lat       <= '0;
      pass_cnt      <= '0;
      iter_done_cnt <= '0;
      pkt_sent_cnt  <= '0;
    end else if (sw_rst) begin
      state         <= IDLE;
      in_pkt        <= 1'b0;
      iter_lat      <= '0;
      pkt_lat       <= '0;
      pass_cnt      <= '0;
      iter_done_cnt <= '0;
      pkt_sent_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (replay_start && !replay_stop && (replay_pkt_cnt != '0)) begin
            iter_lat      <= replay_iter;
            pkt_lat       <= replay_pkt_cnt;
            pass_cnt      <= '0;
            iter_done_cnt <= '0;
            pkt_sent_cnt  <= '0;
            in_pkt        <= 1'b0;
            state         <= RUN;
          end
        end
        RUN, DRAIN: begin
          if (beat) begin
            if (s_axis_tlast) begin
              in_pkt       <= 1'b0;
              pkt_sent_cnt <= pkt_sent_cnt + CNT_ONE;
              if (pass_end) begin
                iter_done_cnt <= iter_done_cnt + CNT_ONE;
                pass_cnt      <= '0;
              end else begin
                pass_cnt <= pass_cnt + CNT_ONE;
              end
              // A stop or drain at a packet boundary always ends the run without rewinding.
              if ((state == DRAIN) || replay_stop || (pass_end && last_pass))
                state <= IDLE;
              else if (pass_end)
                state <= REWIND;
            end else begin
              in_pkt <= 1'b1;
              if (replay_stop)
                state <= DRAIN;
            end
          end else if ((state == RUN) && replay_stop) begin
            state <= in_pkt ? DRAIN : IDLE;
          end
        end
        REWIND: state <= replay_stop ? IDLE : RUN;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcap_replay_scheduler.sv
// tb/tb_pcap_replay_scheduler.sv - randomized self-checking bench for pcap_replay_scheduler
// Source/sink driven cycle by cycle; expectations come from pass/packet arithmetic.
module tb_pcap_replay_scheduler;

  logic         clk;
  logic         axi_aresetn;
  logic         sw_rst;
  logic         replay_start;
  logic         replay_stop;
  logic [31:0]  replay_iter;
  logic [31:0]  replay_pkt_cnt;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tstrb;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic         mem_rd_en;
  logic         mem_rewind;
  logic         replay_busy;
  logic [31:0]  iter_done_cnt;
  logic [31:0]  pkt_sent_cnt;

  pcap_replay_scheduler dut (
    .axi_aclk       (clk),
    .axi_aresetn    (axi_aresetn),
    .sw_rst         (sw_rst),
    .replay_start   (replay_start),
    .replay_stop    (replay_stop),
    .replay_iter    (replay_iter),
    .replay_pkt_cnt (replay_pkt_cnt),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tstrb   (s_axis_tstrb),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tstrb   (m_axis_tstrb),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .mem_rd_en      (mem_rd_en),
    .mem_rewind     (mem_rewind),
    .replay_busy    (replay_busy),
    .iter_done_cnt  (iter_done_cnt),
    .pkt_sent_cnt   (pkt_sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Source model: current beat and its expected copy
  int           src_left;
  int           len_min, len_max;
  bit           rand_valid;
  int           rdy_mode;
  logic [255:0] exp_data;
  logic [31:0]  exp_strb;
  logic [127:0] exp_user;
  logic         exp_last;

  task automatic load_beat();
    for (int i = 0; i < 8; i++) exp_data[i*32 +: 32] = $urandom;
    exp_strb = $urandom;
    exp_user = {$urandom, $urandom, $urandom, $urandom};
    exp_last = (src_left == 1);
    s_axis_tdata = exp_data;
    s_axis_tstrb = exp_strb;
    s_axis_tuser = exp_user;
    s_axis_tlast = exp_last;
  endtask

  task automatic src_setup(input int lmin, input int lmax, input bit rv, input int rm);
    len_min = lmin; len_max = lmax; rand_valid = rv; rdy_mode = rm;
    src_left = $urandom_range(lmin, lmax);
    load_beat();
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
  endtask

  task automatic advance(input bit fired);
    @(posedge clk); #1;
    if (fired) begin
      src_left--;
      if (src_left == 0) src_left = $urandom_range(len_min, len_max);
      load_beat();
      s_axis_tvalid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
    end else if (!s_axis_tvalid) begin
      s_axis_tvalid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic start_run(input int pc, input int it);
    replay_start = 1'b1; replay_pkt_cnt = pc; replay_iter = it;
    advance(1'b0);
    replay_start = 1'b0;
    replay_pkt_cnt = $urandom; replay_iter = $urandom;
  endtask

  task automatic run_beats(input int n);
    bit f;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      f = s_axis_tvalid && m_axis_tready;
      advance(f);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if ({replay_busy, mem_rd_en, mem_rewind, m_axis_tvalid, s_axis_tready} !== 5'b0) begin
      $display("FAIL reset_outputs got=%b want=00000",
               {replay_busy, mem_rd_en, mem_rewind, m_axis_tvalid, s_axis_tready});
    end else n_pass++;
    n_total++;
    if ({iter_done_cnt, pkt_sent_cnt} !== 64'd0) begin
      $display("FAIL reset_counters iter=%0d pkt=%0d want=0/0", iter_done_cnt, pkt_sent_cnt);
    end else n_pass++;
  endtask

  // Generic replay: each pass ends after pc tlasts; a rewind cycle follows every non-final pass.
  task automatic test_passes(input string nm, input int pc, input int it,
                             input int lmin, input int lmax, input bit rv, input int rm);
    int  tlasts, rewinds, cycles;
    bit  done, rew_exp, rew_next, f;
    src_setup(lmin, lmax, rv, rm);
    start_run(pc, it);
    tlasts = 0; rewinds = 0; cycles = 0; done = 0; rew_exp = 0;
    while (!done && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      n_total++;
      if (mem_rewind !== rew_exp || mem_rd_en !== !rew_exp || replay_busy !== 1'b1) begin
        $display("FAIL %s ctrl cyc=%0d rewind=%b rd_en=%b busy=%b want rewind=%b",
                 nm, cycles, mem_rewind, mem_rd_en, replay_busy, rew_exp);
      end else n_pass++;
      n_total++;
      if (s_axis_tready !== (m_axis_tready && !rew_exp) ||
          m_axis_tvalid !== (s_axis_tvalid && !rew_exp)) begin
        $display("FAIL %s handshake cyc=%0d s_rdy=%b m_vld=%b want s_rdy=%b m_vld=%b", nm, cycles,
                 s_axis_tready, m_axis_tvalid, m_axis_tready && !rew_exp, s_axis_tvalid && !rew_exp);
      end else n_pass++;
      f = s_axis_tvalid && m_axis_tready && !rew_exp;
      rew_next = 0;
      if (f) begin
        n_total++;
        if (m_axis_tdata !== exp_data || m_axis_tstrb !== exp_strb ||
            m_axis_tuser !== exp_user || m_axis_tlast !== exp_last) begin
          $display("FAIL %s beat cyc=%0d data=%h last=%b want data=%h last=%b",
                   nm, cycles, m_axis_tdata[63:0], m_axis_tlast, exp_data[63:0], exp_last);
        end else n_pass++;
        if (exp_last) begin
          tlasts++;
          if (tlasts % pc == 0) begin
            if (tlasts == pc * it) done = 1;
            else rew_next = 1;
          end
        end
      end
      if (rew_exp) rewinds++;
      rew_exp = rew_next;
      advance(f);
    end
    n_total++;
    if (!done) $display("FAIL %s timeout tlasts=%0d want=%0d", nm, tlasts, pc * it);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (replay_busy !== 1'b0 || mem_rd_en !== 1'b0 || mem_rewind !== 1'b0) begin
      $display("FAIL %s end_idle busy=%b rd_en=%b rewind=%b want 000", nm, replay_busy, mem_rd_en, mem_rewind);
    end else n_pass++;
    n_total++;
    if (iter_done_cnt !== it || pkt_sent_cnt !== pc * it || rewinds != it - 1) begin
      $display("FAIL %s end_counts iter=%0d pkt=%0d rew=%0d want %0d/%0d/%0d",
               nm, iter_done_cnt, pkt_sent_cnt, rewinds, it, pc * it, it - 1);
    end else n_pass++;
    advance(1'b0);
  endtask

  task automatic test_drain();
    int  after, cycles;
    bit  f, saw_rew, done;
    src_setup(4, 4, 0, 0);
    start_run(2, 0);
    @(negedge clk);
    f = s_axis_tvalid && m_axis_tready;
    advance(f);
    replay_stop = 1'b1;
    after = 0; cycles = 0; saw_rew = 0; done = 0;
    while (!done && cycles < 50) begin
      @(negedge clk);
      cycles++;
      saw_rew |= mem_rewind;
      n_total++;
      if (mem_rd_en !== 1'b1 || replay_busy !== 1'b1) begin
        $display("FAIL drain_active cyc=%0d rd_en=%b busy=%b want 11", cycles, mem_rd_en, replay_busy);
      end else n_pass++;
      f = s_axis_tvalid && m_axis_tready && m_axis_tvalid;
      if (f) begin
        after++;
        done = exp_last;
      end
      advance(f);
      replay_stop = 1'b0;
    end
    @(negedge clk);
    n_total++;
    if (after != 3 || replay_busy !== 1'b0 || mem_rd_en !== 1'b0 || saw_rew || mem_rewind !== 1'b0) begin
      $display("FAIL drain_end beats=%0d busy=%b rd_en=%b rew=%b want 3/0/0/0",
               after, replay_busy, mem_rd_en, saw_rew);
    end else n_pass++;
    n_total++;
    if (pkt_sent_cnt !== 1 || iter_done_cnt !== 0) begin
      $display("FAIL drain_counts pkt=%0d iter=%0d want 1/0", pkt_sent_cnt, iter_done_cnt);
    end else n_pass++;
  endtask

  task automatic test_bad_start();
    src_setup(2, 2, 0, 0);
    start_run(0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (replay_busy !== 1'b0 || mem_rd_en !== 1'b0) begin
        $display("FAIL zero_pkt_start busy=%b rd_en=%b want 00", replay_busy, mem_rd_en);
      end else n_pass++;
      advance(1'b0);
    end
    replay_stop = 1'b1;
    start_run(3, 1);
    replay_stop = 1'b0;
    @(negedge clk);
    n_total++;
    if (replay_busy !== 1'b0 || mem_rd_en !== 1'b0) begin
      $display("FAIL start_with_stop busy=%b rd_en=%b want 00", replay_busy, mem_rd_en);
    end else n_pass++;
    advance(1'b0);
  endtask

  task automatic test_stop_pass_end();
    bit f;
    src_setup(1, 1, 0, 0);
    start_run(2, 3);
    @(negedge clk);
    f = s_axis_tvalid && m_axis_tready;
    advance(f);
    replay_stop = 1'b1;
    @(negedge clk);
    n_total++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1) begin
      $display("FAIL stop_pass_end_beat vld=%b last=%b want 11", m_axis_tvalid, m_axis_tlast);
    end else n_pass++;
    advance(1'b1);
    replay_stop = 1'b0;
    @(negedge clk);
    n_total++;
    if (replay_busy !== 1'b0 || mem_rewind !== 1'b0 || iter_done_cnt !== 1 || pkt_sent_cnt !== 2) begin
      $display("FAIL stop_pass_end busy=%b rew=%b iter=%0d pkt=%0d want 0/0/1/2",
               replay_busy, mem_rewind, iter_done_cnt, pkt_sent_cnt);
    end else n_pass++;
    advance(1'b0);
  endtask

  task automatic test_async_reset();
    src_setup(4, 4, 0, 0);
    start_run(2, 0);
    run_beats(1);
    axi_aresetn = 1'b0;
    #1;
    n_total++;
    if ({replay_busy, mem_rd_en, mem_rewind, m_axis_tvalid, s_axis_tready} !== 5'b0 ||
        iter_done_cnt !== 0 || pkt_sent_cnt !== 0) begin
      $display("FAIL async_reset got=%b iter=%0d pkt=%0d want 00000/0/0",
               {replay_busy, mem_rd_en, mem_rewind, m_axis_tvalid, s_axis_tready},
               iter_done_cnt, pkt_sent_cnt);
    end else n_pass++;
    @(posedge clk); #1;
    axi_aresetn = 1'b1;
    src_setup(2, 2, 0, 0);
    start_run(1, 1);
    @(negedge clk);
    n_total++;
    if (replay_busy !== 1'b1 || mem_rd_en !== 1'b1) begin
      $display("FAIL start_after_release busy=%b rd_en=%b want 11", replay_busy, mem_rd_en);
    end else n_pass++;
    advance(s_axis_tvalid && m_axis_tready);
    sw_rst = 1'b1;
    advance(1'b0);
    sw_rst = 1'b0;
  endtask

  task automatic test_sw_rst();
    src_setup(2, 2, 0, 0);
    start_run(3, 0);
    run_beats(3);
    sw_rst = 1'b1;
    replay_start = 1'b1;
    replay_pkt_cnt = 2;
    @(negedge clk);
    n_total++;
    if (replay_busy !== 1'b1 || pkt_sent_cnt !== 1) begin
      $display("FAIL sw_rst_before_edge busy=%b pkt=%0d want 1/1", replay_busy, pkt_sent_cnt);
    end else n_pass++;
    advance(1'b0);
    sw_rst = 1'b0;
    replay_start = 1'b0;
    @(negedge clk);
    n_total++;
    if ({replay_busy, mem_rd_en, mem_rewind, m_axis_tvalid, s_axis_tready} !== 5'b0 ||
        iter_done_cnt !== 0 || pkt_sent_cnt !== 0) begin
      $display("FAIL sw_rst got=%b iter=%0d pkt=%0d want 00000/0/0",
               {replay_busy, mem_rd_en, mem_rewind, m_axis_tvalid, s_axis_tready},
               iter_done_cnt, pkt_sent_cnt);
    end else n_pass++;
    advance(1'b0);
  endtask

  initial begin
    axi_aresetn = 1'b0; sw_rst = 1'b0; replay_start = 1'b0; replay_stop = 1'b0;
    replay_iter = 0; replay_pkt_cnt = 0;
    src_setup(2, 2, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    axi_aresetn = 1'b1;
    advance(1'b0);
    test_passes("two_pass", 3, 2, 2, 2, 0, 0);
    test_passes("toggle_ready", 2, 1, 1, 4, 0, 1);
    for (int k = 0; k < 3; k++)
      test_passes("random", $urandom_range(1, 4), $urandom_range(1, 3), 1, 4, 1, 2);
    test_drain();
    test_bad_start();
    test_stop_pass_end();
    test_async_reset();
    test_sw_rst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pcap_replay_scheduler.md
PCAP_REPLAY_SCHEDULER -- requirements
Module: pcap_replay_scheduler

Interface
REQ-001 SHALL have parameters: C_M_AXIS_DATA_WIDTH, default 256, stream data width; C_M_AXIS_TUSER_WIDTH, default 128, stream tuser width; C_CNT_WIDTH, default 32, width of all counters and config words.
REQ-002 SHALL have ports as follows (clock and reset first):
- axi_aclk  in  1  sole clock.
- axi_aresetn  in  1  asynchronous, active-low reset.
- sw_rst  in  1  synchronous soft reset, active-high.
- replay_start  in  1  single-cycle start pulse.
- replay_stop  in  1  single-cycle stop pulse.
- replay_iter  in  C_CNT_WIDTH  number of passes; 0 = infinite.
- replay_pkt_cnt  in  C_CNT_WIDTH  packets stored per pass.
- s_axis_tdata/tstrb/tuser/tvalid/tlast  in  DATA/DATA/8/TUSER/1/1  stream from the memory read side.
- s_axis_tready  out  1.
- m_axis_tdata/tstrb/tuser/tvalid/tlast  out  same widths  replay output.
- m_axis_tready  in  1.
- mem_rd_en  out  1  enables the memory read engine.
- mem_rewind  out  1  one-cycle pulse that resets the read pointer to packet 0.
- replay_busy  out  1  high when not IDLE.
- iter_done_cnt  out  C_CNT_WIDTH  completed passes.
- pkt_sent_cnt  out  C_CNT_WIDTH  packets sent since start.

Function
REQ-003 SHALL implement an FSM with states IDLE, RUN, REWIND and DRAIN.
REQ-004 IDLE->RUN SHALL occur on replay_start when replay_stop=0 and replay_pkt_cnt!=0; otherwise IDLE SHALL hold.
REQ-005 On the start transition, the FSM SHALL clear iter_done_cnt, pkt_sent_cnt and the per-pass packet counter, and latch replay_iter and replay_pkt_cnt; config changes during the run SHALL be ignored.
REQ-006 In RUN and DRAIN: m_axis tdata/tstrb/tuser/tlast SHALL equal s_axis combinationally, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready; latency SHALL be 0.
REQ-007 In IDLE and REWIND: m_axis_tvalid=0 and s_axis_tready=0.
REQ-008 A beat SHALL be counted only when tvalid&tready; an in_pkt flag SHALL set on a non-tlast beat and clear on a tlast beat.
REQ-009 Each tlast beat SHALL increment pkt_sent_cnt (wrapping modulo 2^C_CNT_WIDTH) and the per-pass counter.
REQ-010 Pass end is the tlast beat at which per-pass count = latched pkt_cnt-1. At pass end the FSM SHALL increment iter_done_cnt and clear the per-pass counter.
REQ-011 At pass end, if latched iter!=0 and iter_done_cnt+1=latched iter, the FSM SHALL go to IDLE; otherwise it SHALL go to REWIND.
REQ-012 REWIND SHALL last exactly 1 cycle with mem_rewind=1, then go to RUN; mem_rewind SHALL be 0 in all other states.
REQ-013 replay_stop in RUN with in_pkt=0 and no beat that cycle SHALL go to IDLE next cycle.
REQ-014 replay_stop in RUN mid-packet SHALL go to DRAIN; DRAIN SHALL pass beats until the tlast beat, then go to IDLE with no rewind.
REQ-015 replay_stop coincident with a pass-end beat SHALL go to IDLE: the packet is counted, iter_done_cnt increments, and no rewind occurs.
REQ-016 replay_stop in REWIND SHALL go to IDLE.
REQ-017 replay_start while not IDLE SHALL be ignored.
REQ-018 mem_rd_en SHALL be 1 in RUN and DRAIN and 0 otherwise.
REQ-019 replay_busy SHALL be 1 in any state other than IDLE.
REQ-020 sw_rst SHALL override all other inputs and, on the next edge, produce the reset state of REQ-021.

Reset
REQ-021 While axi_aresetn=0, the block SHALL immediately (asynchronously) force: state IDLE, in_pkt=0, all counters 0, mem_rd_en=0, mem_rewind=0, replay_busy=0, m_axis_tvalid=0, s_axis_tready=0.
REQ-022 Reset release SHALL be synchronous to axi_aclk; the first start SHALL be accepted on the cycle after release.

Verification
REQ-023 pkt_cnt=3, iter=2, 2-beat packets, tready=1 -> 6 packets out, exactly 1 mem_rewind pulse after the 3rd tlast, iter_done_cnt=2, pkt_sent_cnt=6, busy=0 the cycle after the 6th tlast.
REQ-024 iter=0, pkt_cnt=2, stop asserted after beat 1 of a 4-beat packet -> DRAIN, 3 more beats pass, then IDLE, mem_rd_en=0, no rewind.
REQ-025 m_axis_tready toggling 1010... with a continuous source -> s_axis_tready mirrors it, output beat sequence identical to input, no loss or duplication.
REQ-026 start with pkt_cnt=0 -> busy remains 0 and mem_rd_en remains 0; start and stop in the same cycle -> remains IDLE.
REQ-027 stop on the final tlast of pass 1 (iter=3) -> IDLE, iter_done_cnt=1, no mem_rewind.
REQ-028 axi_aresetn low mid-packet -> all outputs 0 within the same cycle; sw_rst mid-packet -> same values one edge later.
